// File: rtl/seq_div_u8by4_pkg.sv
// seq_div_u8by4_pkg: shared widths, FSM states and constants for the 8/4 restoring divider
package seq_div_u8by4_pkg;
  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF = 4;
  localparam int CNT_W_DEF = 3;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [DIVIDEND_W_DEF-1:0] Q_ON_ZERO = '1;
endpackage

// File: rtl/seq_div_u8by4_step.sv
// seq_div_u8by4_step: one combinational restoring-division step
module seq_div_u8by4_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] dvs_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_o
);
  logic [DIVISOR_W:0] trial;
  // The stored remainder is always below the divisor, so only the trial needs the extra MSB
  always_comb begin
    trial = {rem_i, bit_i};
    q_o = trial >= {1'b0, dvs_i};
    rem_o = q_o ? trial[DIVISOR_W-1:0] - dvs_i : trial[DIVISOR_W-1:0];
  end
endmodule

// File: rtl/seq_div_u8by4.sv
// seq_div_u8by4: sequential unsigned restoring divider, one quotient bit per cycle; DIV_EARLY_TERM_EN skips CALC when dividend < divisor
module seq_div_u8by4
  import seq_div_u8by4_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W = DIVISOR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  state_t state_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0] dvs_q, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic qbit_d;
  seq_div_u8by4_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_i(rem_q),
    .bit_i(dvd_q[DIVIDEND_W-1]),
    .dvs_i(dvs_q),
    .rem_o(rem_d),
    .q_o(qbit_d)
  );
  // FSM: dvd_q shifts dividend bits out of the top and quotient bits in at the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (divisor == '0) begin
            quotient <= Q_ON_ZERO;
            remainder <= '0;
            div_by_zero <= 1'b1;
            done <= 1'b1;
            state_q <= DONE;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor}) begin
            quotient <= '0;
            remainder <= dividend[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
            done <= 1'b1;
            state_q <= DONE;
          end
`endif
          else begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
            div_by_zero <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIVIDEND_W-1)) begin
            quotient <= {dvd_q[DIVIDEND_W-2:0], qbit_d};
            remainder <= rem_d;
            done <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_u8by4.sv
// tb_seq_div_u8by4: scoreboard bench for the 8/4 restoring divider
module tb_seq_div_u8by4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rst_d = 1'b1;
  logic [7:0] dividend = '0, quotient;
  logic [3:0] divisor = '0, remainder;
  logic busy, done, div_by_zero;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic z;
    int s;
    int dc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] hq = '0;
  logic [3:0] hr = '0;
  logic hz = 1'b0;
`ifdef DIV_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  seq_div_u8by4 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, got, want, cyc);
    end
  endtask

  function automatic int lat_of(input logic [7:0] a, input logic [3:0] b);
    return (b == 0 || (EARLY && a < {4'd0, b})) ? 1 : 9;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] a, input logic [3:0] b, input bit push);
    exp_t x;
    dividend = a;
    divisor = b;
    start = 1'b1;
    if (push) begin
      x.z = (b == 0);
      x.q = x.z ? 8'hff : a / {4'd0, b};
      x.r = x.z ? 4'd0 : 4'(a % {4'd0, b});
      x.s = cyc;
      x.dc = cyc + lat_of(a, b);
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 4'($urandom);
  endtask

  always @(negedge clk) begin
    if (rst_d) begin
      sb.delete();
      hq = '0;
      hr = '0;
      hz = 1'b0;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_quotient", {24'd0, quotient}, 0);
      chk("rst_remainder", {28'd0, remainder}, 0);
      chk("rst_dbz", {31'd0, div_by_zero}, 0);
    end else if (done) begin
      if (sb.size() == 0) chk("spurious_done", {31'd0, done}, 0);
      else begin
        e = sb[0];
        sb.delete(0);
        chk("done_cycle", cyc, e.dc);
        chk("quotient", {24'd0, quotient}, {24'd0, e.q});
        chk("remainder", {28'd0, remainder}, {28'd0, e.r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        chk("busy_at_done", {31'd0, busy}, 1);
        hq = e.q;
        hr = e.r;
        hz = e.z;
      end
    end else begin
      if (sb.size() > 0 && cyc > sb[0].dc) begin
        chk("done_timeout", {31'd0, done}, 1);
        sb.delete(0);
      end
      chk("busy", {31'd0, busy}, (sb.size() > 0 && cyc > sb[0].s) ? 1 : 0);
      if (!busy) begin
        chk("hold_quotient", {24'd0, quotient}, {24'd0, hq});
        chk("hold_remainder", {28'd0, remainder}, {28'd0, hr});
        chk("hold_dbz", {31'd0, div_by_zero}, {31'd0, hz});
      end
    end
  end

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    pulse(200, 7, 1); idle(9);
    pulse(255, 15, 1); idle(9);
    pulse(128, 1, 1); idle(9);
    pulse(9, 0, 1); idle(1);
    pulse(9, 3, 1); idle(9);
    pulse(3, 5, 1); idle(lat_of(3, 5));
    pulse(100, 9, 1); idle(2);
    pulse(50, 2, 0); idle(1);
    pulse(50, 2, 0); idle(4);
    pulse(100, 9, 1); idle(3);
    rst = 1'b1; idle(1);
    rst = 1'b0; idle(12);
    pulse(100, 9, 1); idle(9);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++) begin
        pulse(8'(a), 4'(b), 1);
        idle(lat_of(8'(a), 4'(b)) + int'($urandom_range(0, 1)));
      end
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom);
      b = 4'($urandom);
      pulse(a, b, 1);
      idle(lat_of(a, b) + int'($urandom_range(0, 2)));
    end
    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
